// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: oversample ratio, counter width,
// FSM state encoding and the parity-check helper.
package uart_rx_pkg;

  localparam int OVS       = 16;          // oversample ticks per bit period
  localparam int START_MID = OVS / 2 - 1; // tick index at the centre of the start bit
  localparam int BIT_LAST  = OVS - 1;     // tick index at the centre of data/parity bits
  localparam int S_W       = 5;           // tick counter width, covers stop lengths up to 32 ticks

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // Running XOR of the data bits combined with the received parity bit must equal
  // the selected sense (0 = even, 1 = odd); anything else is a parity error.
  function automatic logic parity_mismatch(input logic data_xor, input logic rx_par,
                                           input logic odd);
    return (data_xor ^ rx_par) != odd;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver: LSB-first data, optional parity, stop-bit check,
// and a registered one-cycle done strobe qualified by frame/parity error flags.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PAR_EN  = 0,
  parameter int PAR_ODD = 0
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_rx,
  input  logic            i_s_tick,
  output logic            o_rx_done_tick,
  output logic [DBIT-1:0] o_dout,
  output logic            o_parity_err,
  output logic            o_frame_err
);

  localparam int   N_W      = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic HAS_PAR  = (PAR_EN != 0);
  localparam logic ODD_PAR  = (PAR_ODD != 0);

  state_e            state_q;
  logic [S_W-1:0]    s_q;
  logic [N_W-1:0]    n_q;
  logic [DBIT-1:0]   b_q;
  logic              par_acc_q;
  logic              rx_par_q;
  logic              done_q;
  logic [DBIT-1:0]   dout_q;
  logic              perr_q;
  logic              ferr_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ST_IDLE;
      s_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      par_acc_q <= 1'b0;
      rx_par_q  <= 1'b0;
      done_q    <= 1'b0;
      dout_q    <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Start detection does not wait for a tick, so a line still low when the
          // previous frame ends is picked up on the very next cycle.
          if (!i_rx) begin
            state_q <= ST_START;
            s_q     <= '0;
          end
        end

        ST_START: begin
          if (i_s_tick) begin
            if (s_q == S_W'(START_MID)) begin
              if (!i_rx) begin
                state_q   <= ST_DATA;
                s_q       <= '0;
                n_q       <= '0;
                par_acc_q <= 1'b0;
              end else begin
                state_q <= ST_IDLE;
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end

        ST_DATA: begin
          if (i_s_tick) begin
            if (s_q == S_W'(BIT_LAST)) begin
              s_q       <= '0;
              b_q       <= {i_rx, b_q[DBIT-1:1]};
              par_acc_q <= par_acc_q ^ i_rx;
              if (n_q == N_W'(DBIT - 1)) begin
                state_q <= HAS_PAR ? ST_PARITY : ST_STOP;
              end else begin
                n_q <= n_q + 1'b1;
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end

        ST_PARITY: begin
          if (i_s_tick) begin
            if (s_q == S_W'(BIT_LAST)) begin
              s_q      <= '0;
              rx_par_q <= i_rx;
              state_q  <= ST_STOP;
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end

        ST_STOP: begin
          if (i_s_tick) begin
            if (s_q == S_W'(SB_TICK - 1)) begin
              // Strobe fires regardless of errors; the flags qualify the word.
              done_q  <= 1'b1;
              dout_q  <= b_q;
              ferr_q  <= ~i_rx;
              perr_q  <= HAS_PAR & parity_mismatch(par_acc_q, rx_par_q, ODD_PAR);
              s_q     <= '0;
              state_q <= ST_IDLE;
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
          s_q     <= '0;
        end
      endcase
    end
  end

  assign o_rx_done_tick = done_q;
  assign o_dout         = dout_q;
  assign o_parity_err   = perr_q;
  assign o_frame_err    = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8N1 receiver and an 8E1 receiver driven with directed and
// randomized frames, each checked every cycle against a queue of expected words.
module tb_uart_rx;

  localparam int BIT_CLK = 64;  // tick every 4th clock, 16 ticks per bit

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       rx0 = 1'b1;
  logic       rx1 = 1'b1;
  logic       done0, done1, pe0, pe1, fe0, fe1;
  logic [7:0] d0, d1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t h0, h1;
  logic prev_done0 = 1'b0;
  logic prev_done1 = 1'b0;

  always #5 clk = ~clk;

  uart_rx #(.DBIT(8), .SB_TICK(16), .PAR_EN(0), .PAR_ODD(0)) dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_rx(rx0), .i_s_tick(tick),
    .o_rx_done_tick(done0), .o_dout(d0), .o_parity_err(pe0), .o_frame_err(fe0)
  );

  uart_rx #(.DBIT(8), .SB_TICK(16), .PAR_EN(1), .PAR_ODD(0)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_rx(rx1), .i_s_tick(tick),
    .o_rx_done_tick(done1), .o_dout(d1), .o_parity_err(pe1), .o_frame_err(fe1)
  );

  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Even parity: total count of ones over data+parity must be even.
  function automatic exp_t model(input int inst, input logic [7:0] data,
                                 input logic stop_bit, input logic par_bit);
    exp_t e;
    e.d  = data;
    e.fe = !stop_bit;
    e.pe = (inst == 1) ? ((($countones(data) + int'(par_bit)) % 2) != 0) : 1'b0;
    return e;
  endfunction

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        h0 = '{8'h00, 1'b0, 1'b0};
        h1 = '{8'h00, 1'b0, 1'b0};
        check("rst_done0", 32'(done0), 32'd0);
        check("rst_done1", 32'(done1), 32'd0);
      end else begin
        if (done0) begin
          if (q0.size() == 0) check("unexpected_strobe0", 32'(done0), 32'd0);
          else h0 = q0.pop_front();
          if (prev_done0) check("strobe_width0", 32'(done0), 32'd0);
        end
        if (done1) begin
          if (q1.size() == 0) check("unexpected_strobe1", 32'(done1), 32'd0);
          else h1 = q1.pop_front();
          if (prev_done1) check("strobe_width1", 32'(done1), 32'd0);
        end
      end
      check("dout0", 32'(d0), 32'(h0.d));
      check("ferr0", 32'(fe0), 32'(h0.fe));
      check("perr0", 32'(pe0), 32'(h0.pe));
      check("dout1", 32'(d1), 32'(h1.d));
      check("ferr1", 32'(fe1), 32'(h1.fe));
      check("perr1", 32'(pe1), 32'(h1.pe));
      prev_done0 = done0;
      prev_done1 = done1;
    end
  endtask

  task automatic drive(input int inst, input logic v, input int len);
    if (inst == 0) rx0 = v;
    else rx1 = v;
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int inst, input logic [7:0] data, input logic stop_bit,
                            input logic par_bit, input int gap);
    int g;
    g = gap;
    if (inst == 0) q0.push_back(model(0, data, stop_bit, par_bit));
    else q1.push_back(model(1, data, stop_bit, par_bit));
    drive(inst, 1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) drive(inst, data[i], BIT_CLK);
    if (inst == 1) drive(inst, par_bit, BIT_CLK);
    // A bad stop bit is held only past its centre so the receiver's re-armed
    // start detector sees the line high again and rejects it.
    if (stop_bit) drive(inst, 1'b1, BIT_CLK);
    else begin
      drive(inst, 1'b0, 44);
      if (g < BIT_CLK) g = BIT_CLK;
    end
    if (inst == 0) rx0 = 1'b1;
    else rx1 = 1'b1;
    check("strobe_latency", 32'((inst == 0) ? q0.size() : q1.size()), 32'd0);
    for (int k = 0; k < g; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int inst;
    logic [7:0] data;
    logic stop_bit, par_bit;
    fork
      compare_loop();
    join_none

    // 1) reset while idle, then release and receive 0xA5
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t1_reset_dout", 32'(d0), 32'h0);
    check("t1_reset_done", 32'(done0), 32'h0);
    repeat (20) @(posedge clk);
    #1;
    send_frame(0, 8'hA5, 1'b1, 1'b0, 40);
    check("t1_dout", 32'(d0), 32'hA5);
    check("t1_ferr", 32'(fe0), 32'h0);
    check("t1_perr", 32'(pe0), 32'h0);

    // 2) back-to-back 0x00 then 0xFF
    send_frame(0, 8'h00, 1'b1, 1'b0, 0);
    check("t2_first", 32'(d0), 32'h00);
    send_frame(0, 8'hFF, 1'b1, 1'b0, 30);
    check("t2_second", 32'(d0), 32'hFF);

    // 3) short low glitch: no frame
    drive(0, 1'b0, 12);
    drive(0, 1'b1, 200);
    check("t3_glitch_dout", 32'(d0), 32'hFF);

    // 4) bad stop bit, then a good frame clears the flag
    send_frame(0, 8'h3C, 1'b0, 1'b0, 64);
    check("t4_dout", 32'(d0), 32'h3C);
    check("t4_ferr", 32'(fe0), 32'h1);
    send_frame(0, 8'h81, 1'b1, 1'b0, 30);
    check("t4_ferr_clear", 32'(fe0), 32'h0);

    // 5) even parity receiver
    send_frame(1, 8'h01, 1'b1, 1'b1, 30);
    check("t5_perr_ok", 32'(pe1), 32'h0);
    check("t5_dout", 32'(d1), 32'h01);
    send_frame(1, 8'h01, 1'b1, 1'b0, 30);
    check("t5_perr_bad", 32'(pe1), 32'h1);

    // 6) reset during data bit 4 of 0x5A
    drive(0, 1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) drive(0, (8'h5A >> i) & 8'h01, BIT_CLK);
    drive(0, 1'b1, 32);
    rst_n = 1'b0;
    #1;
    check("t6_async_dout0", 32'(d0), 32'h0);
    check("t6_async_dout1", 32'(d1), 32'h0);
    check("t6_async_perr1", 32'(pe1), 32'h0);
    rx0 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (BIT_CLK) @(posedge clk);
    #1;
    send_frame(0, 8'h5A, 1'b1, 1'b0, 30);
    check("t6_dout", 32'(d0), 32'h5A);

    // randomized frames on both receivers
    for (int k = 0; k < 24; k++) begin
      inst     = int'($urandom_range(0, 1));
      data     = 8'($urandom);
      stop_bit = ($urandom_range(0, 7) != 0);
      par_bit  = (^data) ^ ($urandom_range(0, 3) == 0);
      send_frame(inst, data, stop_bit, par_bit, int'($urandom_range(0, 80)));
    end

    for (int k = 0; k < 3000; k++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      @(posedge clk);
    end
    repeat (10) @(posedge clk);
    #1;
    check("drain_q0", 32'(q0.size()), 32'd0);
    check("drain_q1", 32'(q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
